// File: rtl/sequencer.sv
// sequencer: microprogram next-address sequencer with a wrap-around subroutine stack
module sequencer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] yout
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {NEXT, JUMP, CALL, RET} op_t;
  op_t              opc;
  logic [WIDTH-1:0] upc;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [AW-1:0]    sp, sp_dec;
  assign opc    = op_t'(op);
  assign sp_dec = sp - AW'(1);
  always_comb
    yout = !reset ? '0 : opc == NEXT ? upc : opc == RET ? stack[sp_dec] : din;
  // pointer arithmetic wraps silently: overflow overwrites the oldest entry, underflow reads the top slot
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      upc <= '0;
      sp  <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      upc <= yout + WIDTH'(1);
      if (opc == CALL) begin
        stack[sp] <= upc;
        sp        <= sp + AW'(1);
      end else if (opc == RET) sp <= sp_dec;
    end
endmodule

// File: tb/tb_sequencer.sv
// tb_sequencer: directed vector table, async-reset corner case and randomized run against a reference model
module tb_sequencer;
  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam logic [1:0] NEXT = 2'd0, JUMP = 2'd1, CALL = 2'd2, RET = 2'd3;
  typedef struct {
    logic [1:0]  op;
    logic [11:0] din;
    int          exp;
  } vec_t;
  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] yout;
  int n_checks = 0;
  int n_fail   = 0;
  int m_upc;
  int m_sp;
  int m_stk [DEPTH];
  vec_t tbl [$];
  sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .op(op), .din(din), .yout(yout)
  );
  always #5 clock = ~clock;
  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: yout=%03h expected %03h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_upc = 0;
    m_sp  = 0;
    for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
  endtask
  function automatic int model_y(input logic [1:0] o, input logic [11:0] d);
    return o == NEXT ? m_upc : o == RET ? m_stk[(m_sp + DEPTH - 1) % DEPTH] : int'(d);
  endfunction
  task automatic model_clk(input logic [1:0] o, input logic [11:0] d);
    int y;
    y = model_y(o, d);
    if (o == CALL) begin
      m_stk[m_sp] = m_upc;
      m_sp = (m_sp + 1) % DEPTH;
    end else if (o == RET) m_sp = (m_sp + DEPTH - 1) % DEPTH;
    m_upc = (y + 1) % (1 << WIDTH);
  endtask
  task automatic apply(input logic [1:0] o, input logic [11:0] d, input int e, input string nm);
    op  = o;
    din = d;
    #1;
    check(nm, int'(yout), e);
    model_clk(o, d);
    @(posedge clock);
    #1;
  endtask
  initial begin
    logic [1:0]  ro;
    logic [11:0] rd;
    tbl.push_back('{NEXT, 12'h000, 'h000});
    tbl.push_back('{NEXT, 12'h000, 'h001});
    tbl.push_back('{NEXT, 12'h000, 'h002});
    tbl.push_back('{JUMP, 12'h123, 'h123});
    tbl.push_back('{NEXT, 12'h000, 'h124});
    tbl.push_back('{JUMP, 12'h004, 'h004});
    tbl.push_back('{CALL, 12'h200, 'h200});
    tbl.push_back('{NEXT, 12'h000, 'h201});
    tbl.push_back('{RET,  12'h000, 'h005});
    tbl.push_back('{NEXT, 12'h000, 'h006});
    for (int k = 1; k <= 4; k++) begin
      tbl.push_back('{JUMP, 12'(k * 16 - 1), k * 16 - 1});
      tbl.push_back('{CALL, 12'h300, 'h300});
    end
    for (int k = 4; k >= 1; k--) tbl.push_back('{RET, 12'h000, k * 16});
    for (int k = 1; k <= 5; k++) begin
      tbl.push_back('{JUMP, 12'(k * 16 - 1), k * 16 - 1});
      tbl.push_back('{CALL, 12'h400, 'h400});
    end
    tbl.push_back('{RET, 12'h000, 'h050});
    tbl.push_back('{RET, 12'h000, 'h040});
    tbl.push_back('{RET, 12'h000, 'h030});
    tbl.push_back('{RET, 12'h000, 'h020});
    tbl.push_back('{RET, 12'h000, 'h050});
    tbl.push_back('{JUMP, 12'hFFF, 'hFFF});
    tbl.push_back('{NEXT, 12'h000, 'h000});
    reset = 1'b0;
    op    = JUMP;
    din   = 12'hABC;
    model_reset();
    #2;
    check("reset_hold", int'(yout), 0);
    @(posedge clock);
    #1;
    check("reset_hold_edge", int'(yout), 0);
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].op, tbl[i].din, tbl[i].exp, $sformatf("vec%0d", i));
    apply(CALL, 12'h600, 'h600, "call_before_reset");
    op    = CALL;
    din   = 12'h777;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_yout", int'(yout), 0);
    #1;
    reset = 1'b1;
    apply(RET, 12'h000, 'h000, "ret_after_reset");
    apply(NEXT, 12'h000, 'h001, "next_after_reset");
    for (int i = 0; i < 400; i++) begin
      ro = 2'($urandom_range(0, 3));
      rd = 12'($urandom_range(0, 4095));
      apply(ro, rd, model_y(ro, rd), $sformatf("rand%0d", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
